// File: rtl/word_ser_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and the
// default geometry of the held word (128-bit word, 4-bit lane select).
package word_ser_pkg;

    // Serializer FSM: IDLE waits for a word, SHIFT emits its lanes.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Default held-word width in bits.
    localparam int IN_D_W_DEF = 128;

    // Default lane-select width; the word is split into 2**S_W lanes.
    localparam int S_W_DEF = 4;

    // Lane width for a given word width and select width.
    function automatic int lane_width(input int word_w, input int sel_w);
        return word_w / (2 ** sel_w);
    endfunction

endpackage : word_ser_pkg

// File: rtl/mux_g.sv
// Generic lane multiplexer: splits A into 2**S_W equal lanes and returns
// lane S on Y. Lane i occupies A[i*Y_W +: Y_W].
module mux_g #(
    parameter int A_W = 128,
    parameter int S_W = 4
) (
    input  logic [A_W-1:0]            A,
    input  logic [S_W-1:0]            S,
    output logic [A_W/(2**S_W)-1:0]   Y
);

    localparam int Y_W    = A_W / (2 ** S_W);
    localparam int LANES  = 2 ** S_W;

    // Select the lane whose index matches S; the loop keeps every index constant.
    always_comb begin
        Y = '0;
        for (int i = 0; i < LANES; i++) begin
            if (S == S_W'(i)) begin
                Y = A[i*Y_W +: Y_W];
            end
        end
    end

endmodule : mux_g

// File: rtl/word_serializer_ctrl.sv
// Word serializer: captures a wide word with a last-lane index and emits it
// one lane per accepted output beat, lane 0 first. A new word may be taken
// on the same cycle the last lane is consumed, so back-to-back words stream
// without a bubble. flush aborts the word in progress.
// Optional feature: define WORD_SERIALIZER_LAST_EN to add the out_last port.
module word_serializer_ctrl
    import word_ser_pkg::*;
#(
    parameter int In_d_W = IN_D_W_DEF,
    parameter int S_W    = S_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [In_d_W-1:0]           in_data,
    input  logic [S_W-1:0]              in_len,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [In_d_W/(2**S_W)-1:0]  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
`ifdef WORD_SERIALIZER_LAST_EN
    output logic                        out_last,
`endif
    output logic [S_W-1:0]              sel
);

    localparam int Out_d_W = In_d_W / (2 ** S_W);

    state_e              state_q;
    state_e              state_d;
    logic [In_d_W-1:0]   word_q;
    logic [In_d_W-1:0]   word_d;
    logic [S_W-1:0]      len_q;
    logic [S_W-1:0]      len_d;
    logic [S_W-1:0]      sel_q;
    logic [S_W-1:0]      sel_d;

    logic                in_shift;
    logic                last_lane;
    logic                beat_done;
    logic                accept;

    // Handshake decode shared by the next-state and datapath logic.
    always_comb begin
        in_shift  = (state_q == SHIFT);
        last_lane = (sel_q == len_q);
        beat_done = in_shift && out_ready;
        accept    = in_valid && in_ready;
    end

    // State register; reset returns to IDLE and abandons any word in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush dominates, then a new word, then end-of-word.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = SHIFT;
        end else if (beat_done && last_lane) begin
            state_d = IDLE;
        end
    end

    // Datapath registers: held word, last-lane index and current lane.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            len_q  <= '0;
            sel_q  <= '0;
        end else begin
            word_q <= word_d;
            len_q  <= len_d;
            sel_q  <= sel_d;
        end
    end

    // Datapath next values; sel only advances while below len, so it never wraps.
    always_comb begin
        word_d = word_q;
        len_d  = len_q;
        sel_d  = sel_q;
        if (flush) begin
            sel_d = '0;
        end else if (accept) begin
            word_d = in_data;
            len_d  = in_len;
            sel_d  = '0;
        end else if (beat_done && !last_lane) begin
            sel_d = sel_q + 1'b1;
        end
    end

    // Outputs: in_ready also opens when the final lane is being consumed.
    always_comb begin
        out_valid = in_shift;
        in_ready  = !flush && ((state_q == IDLE) || (in_shift && last_lane && out_ready));
        sel       = sel_q;
`ifdef WORD_SERIALIZER_LAST_EN
        out_last  = in_shift && last_lane;
`endif
    end

    mux_g #(
        .A_W (In_d_W),
        .S_W (S_W)
    ) u_lane_mux (
        .A (word_q),
        .S (sel_q),
        .Y (out_data)
    );

    if (Out_d_W * (2 ** S_W) != In_d_W) begin : g_bad_geometry
        $error("In_d_W must be a multiple of 2**S_W");
    end

endmodule : word_serializer_ctrl

// File: tb/tb_word_serializer_ctrl.sv
// Directed bench for word_serializer_ctrl with default parameters.
// Inputs are driven 1 time unit after each rising edge; outputs are
// compared one further unit later, well away from the next edge.
module tb_word_serializer_ctrl;

    logic         clk;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_len;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         flush;
    logic [3:0]   sel;
`ifdef WORD_SERIALIZER_LAST_EN
    logic         out_last;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] W_RAMP = 128'h0F0E0D0C0B0A09080706050403020100;

    word_serializer_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
`ifdef WORD_SERIALIZER_LAST_EN
        .out_last  (out_last),
`endif
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then settle one unit for input driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_len    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        tick();
        tick();

        // Reset state
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_sel",       128'(sel),       128'(4'd0));
        chk("rst_out_data",  128'(out_data),  128'(8'h00));
        chk("rst_in_ready",  128'(in_ready),  128'(1'b1));
        rst_n = 1'b1;

        // Full 16-lane word with out_ready held high
        tick();
        in_data = W_RAMP; in_len = 4'd15; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("ramp_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("ramp_valid", 128'(out_valid), 128'(1'b1));
            chk("ramp_data",  128'(out_data),  128'(i));
            chk("ramp_sel",   128'(sel),       128'(i));
`ifdef WORD_SERIALIZER_LAST_EN
            chk("ramp_last",  128'(out_last),  128'(i == 15));
`endif
            tick();
        end
        #1;
        chk("ramp_end_valid", 128'(out_valid), 128'(1'b0));
        chk("ramp_end_ready", 128'(in_ready),  128'(1'b1));

        // Single lane word
        tick();
        in_data = {120'hFFEEDDCCBBAA998877665544332211, 8'hA5}; in_len = 4'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("one_valid", 128'(out_valid), 128'(1'b1));
        chk("one_data",  128'(out_data),  128'(8'hA5));
`ifdef WORD_SERIALIZER_LAST_EN
        chk("one_last",  128'(out_last),  128'(1'b1));
`endif
        tick();
        #1;
        chk("one_end_valid", 128'(out_valid), 128'(1'b0));

        // Stalled output: each lane held for one stall cycle then taken
        tick();
        in_data = {96'h0, 32'h44332211}; in_len = 4'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            out_ready = 1'b0;
            #1;
            chk("stall_data",  128'(out_data), 128'((b + 1) * 8'h11));
            chk("stall_sel",   128'(sel),      128'(b));
            chk("stall_valid", 128'(out_valid), 128'(1'b1));
            tick();
            out_ready = 1'b1;
            #1;
            chk("stall_hold_data", 128'(out_data), 128'((b + 1) * 8'h11));
            chk("stall_hold_sel",  128'(sel),      128'(b));
            tick();
        end
        #1;
        chk("stall_end_valid", 128'(out_valid), 128'(1'b0));

        // Back-to-back two-lane words with no bubble
        tick();
        in_data = {112'h0, 16'hB1B0}; in_len = 4'd1; in_valid = 1'b1;
        tick();
        in_data = {112'h0, 16'hC1C0};
        #1;
        chk("b2b_busy_ready", 128'(in_ready), 128'(1'b0));
        chk("b2b_d0",         128'(out_data), 128'(8'hB0));
        tick();
        #1;
        chk("b2b_reload_ready", 128'(in_ready), 128'(1'b1));
        chk("b2b_d1",           128'(out_data), 128'(8'hB1));
        tick();
        in_valid = 1'b0;
        #1;
        chk("b2b_d2",     128'(out_data),  128'(8'hC0));
        chk("b2b_d2_vld", 128'(out_valid), 128'(1'b1));
        chk("b2b_d2_sel", 128'(sel),       128'(4'd0));
        tick();
        #1;
        chk("b2b_d3",     128'(out_data),  128'(8'hC1));
        chk("b2b_d3_vld", 128'(out_valid), 128'(1'b1));
        tick();
        #1;
        chk("b2b_end_valid", 128'(out_valid), 128'(1'b0));

        // Flush at lane 5 with a competing input word
        tick();
        in_data = W_RAMP; in_len = 4'd15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        in_data = {112'h0, 16'hEEEE}; in_valid = 1'b1; flush = 1'b1;
        #1;
        chk("flush_at_sel",   128'(sel),      128'(4'd5));
        chk("flush_at_data",  128'(out_data), 128'(8'h05));
        chk("flush_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 128'(out_valid), 128'(1'b0));
        chk("flush_sel",       128'(sel),       128'(4'd0));
        tick();
        in_data = {112'h0, 16'hD1D0}; in_len = 4'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_flush_d0",  128'(out_data), 128'(8'hD0));
        chk("post_flush_sel", 128'(sel),      128'(4'd0));
        tick();
        #1;
        chk("post_flush_d1", 128'(out_data), 128'(8'hD1));
        tick();

        // Reset mid-word at lane 7
        in_data = W_RAMP; in_len = 4'd15; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        #1;
        chk("mid_rst_at_sel", 128'(sel), 128'(4'd7));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid",    128'(out_valid), 128'(1'b0));
        chk("mid_rst_sel",      128'(sel),       128'(4'd0));
        chk("mid_rst_data",     128'(out_data),  128'(8'h00));
        chk("mid_rst_in_ready", 128'(in_ready),  128'(1'b1));
`ifdef WORD_SERIALIZER_LAST_EN
        chk("mid_rst_last",     128'(out_last),  128'(1'b0));
`endif
        in_data = {120'h0, 8'h5A}; in_len = 4'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("post_rst_valid", 128'(out_valid), 128'(1'b1));
        chk("post_rst_data",  128'(out_data),  128'(8'h5A));
        tick();
        #1;
        chk("post_rst_end", 128'(out_valid), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_word_serializer_ctrl

// File: doc/word_serializer_ctrl.md
WORD_SERIALIZER_CTRL -- requirements
Module: word_serializer_ctrl

Interface
REQ-001 SHALL have parameter In_d_W, default 128, meaning the width of the held input word in bits.
REQ-002 SHALL have parameter S_W, default 4, meaning the lane-select width; lane width Out_d_W = In_d_W/2**S_W (default 8).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; synchronous and active-low.
REQ-005 SHALL have port in_data, input, In_d_W, meaning the word to serialize; lane i = bits [i*Out_d_W +: Out_d_W].
REQ-006 SHALL have port in_len, input, S_W, meaning the index of the last lane to emit (0 = 1 lane, 2**S_W-1 = all lanes).
REQ-007 SHALL have port in_valid, input, 1, meaning in_data/in_len are valid.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-009 SHALL have port out_data, output, Out_d_W, meaning the current lane.
REQ-010 SHALL have port out_valid, output, 1, meaning out_data is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts out_data.
REQ-012 SHALL have port flush, input, 1, meaning a synchronous abort of the word in progress.
REQ-013 SHALL have port sel, output, S_W, meaning the current lane index (debug/observation).

Function
REQ-014 SHALL implement states IDLE and SHIFT; in_ready = 1 in IDLE.
REQ-015 SHALL, on in_valid && in_ready with flush = 0, register in_data and in_len, set sel = 0 and enter SHIFT the next cycle.
REQ-016 SHALL assert out_valid only in SHIFT and drive out_data = lane sel of the registered word.
REQ-017 SHALL hold out_data and sel stable while out_valid && !out_ready.
REQ-018 SHALL, on out_valid && out_ready with sel < len, increment sel by 1.
REQ-019 SHALL, on out_valid && out_ready with sel == len, return to IDLE unless a new word is accepted the same cycle.
REQ-020 SHALL also assert in_ready in SHIFT when sel == len && out_ready (combinational path from out_ready); a word accepted then reloads sel = 0 and stays in SHIFT, giving zero bubble cycles between words.
REQ-021 SHALL give a latency of 1 cycle from input handshake to first out_valid; throughput is 1 lane per cycle with out_ready held high.
REQ-022 SHALL, on flush = 1, enter IDLE next cycle with sel = 0; in_ready = 0 during flush; flush wins over all simultaneous handshakes.
REQ-023 SHALL never let sel exceed len; len = 2**S_W-1 ends at the all-ones index without wrap.

Reset
REQ-024 SHALL, with rst_n = 0 at a clock edge, set state = IDLE, sel = 0, out_valid = 0, out_data = 0 and the registered word/len to 0, aborting any word in progress.
REQ-025 SHALL accept a word on the first edge after rst_n returns high.

Configuration
REQ-026 SHALL, with macro WORD_SERIALIZER_LAST_EN defined, add output out_last (1 bit) = out_valid && (sel == len), reset value 0.
REQ-027 SHALL, without WORD_SERIALIZER_LAST_EN, omit out_last; all other behaviour is identical.

Structure
REQ-028 SHALL take the state enum (IDLE, SHIFT) and default In_d_W/S_W constants from a shared package word_ser_pkg.
REQ-029 SHALL perform lane selection with one instance of the existing mux_g (A = registered word, S = sel, Y = out_data); no other sub-modules.

Verification
REQ-030 SHALL cover single word 0x0F0E..0100, len 15, out_ready = 1 -> out_data 0x00..0x0F on 16 consecutive cycles, then in_ready = 1.
REQ-031 SHALL cover len 0, word lane0 = 0xA5 -> exactly one beat of 0xA5, out_last = 1 when enabled.
REQ-032 SHALL cover out_ready toggling 1/0 with len 3 -> 4 beats, out_data/sel unchanged across stall cycles.
REQ-033 SHALL cover back-to-back words, len 1 each, in_valid held -> beats at 4 consecutive cycles, no bubble.
REQ-034 SHALL cover flush at sel = 5, len 15 -> IDLE next cycle, out_valid = 0, sel = 0; the next word starts at lane 0.
REQ-035 SHALL cover rst_n low mid-word at sel = 7 -> all outputs at their reset values next cycle; a new word after release emits correctly.
